// File: rtl/wptr_handler_lvl.sv
// Write-domain pointer stage of the asynchronous FIFO: binary/Gray write pointers,
// registered full, conservative fill level, almost-full and sticky overflow.
module wptr_handler_lvl #(
    parameter int WIDTH        = 8,
    parameter int AFULL_MARGIN = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             w_en,
    input  logic             ovf_clr,
    input  logic [WIDTH:0]   g_rptr_sync,
    output logic [WIDTH:0]   b_wptr,
    output logic [WIDTH:0]   g_wptr,
    output logic             full,
    output logic             almost_full,
    output logic [WIDTH:0]   wlevel,
    output logic             overflow
);

    localparam int              DEPTH        = 1 << WIDTH;
    localparam logic [WIDTH:0]  AFULL_THRESH = (WIDTH + 1)'(DEPTH - AFULL_MARGIN);

    function automatic logic [WIDTH:0] bin2gray(input logic [WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
        logic [WIDTH:0] b;
        b[WIDTH] = g[WIDTH];
        for (int i = WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH:0] r_b_wptr;
    logic [WIDTH:0] r_g_wptr;
    logic           r_full;
    logic           r_afull;
    logic [WIDTH:0] r_level;
    logic           r_overflow;

    logic           w_wr_acc;
    logic [WIDTH:0] w_b_wptr_next;
    logic [WIDTH:0] w_g_wptr_next;
    logic [WIDTH:0] w_b_rptr;
    logic           w_full_next;
    logic [WIDTH:0] w_level_next;
    logic           w_afull_next;
    logic           w_ovf_next;

    // Next-state pointer, level and flag computation
    always_comb begin
        w_wr_acc      = w_en & ~r_full;
        w_b_wptr_next = r_b_wptr + {{WIDTH{1'b0}}, w_wr_acc};
        w_g_wptr_next = bin2gray(w_b_wptr_next);
        w_b_rptr      = gray2bin(g_rptr_sync);
        // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted
        w_full_next   = (w_g_wptr_next == {~g_rptr_sync[WIDTH:WIDTH-1], g_rptr_sync[WIDTH-2:0]});
        w_level_next  = w_b_wptr_next - w_b_rptr;
        w_afull_next  = (w_level_next >= AFULL_THRESH);
        if (w_en & r_full) begin
            w_ovf_next = 1'b1;
        end else if (ovf_clr) begin
            w_ovf_next = 1'b0;
        end else begin
            w_ovf_next = r_overflow;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_b_wptr   <= '0;
            r_g_wptr   <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_b_wptr   <= w_b_wptr_next;
            r_g_wptr   <= w_g_wptr_next;
            r_full     <= w_full_next;
            r_afull    <= w_afull_next;
            r_level    <= w_level_next;
            r_overflow <= w_ovf_next;
        end
    end

    assign b_wptr      = r_b_wptr;
    assign g_wptr      = r_g_wptr;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign wlevel      = r_level;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_wptr_handler_lvl.sv
// Randomized self-checking bench for wptr_handler_lvl (WIDTH=3, AFULL_MARGIN=2)
// against an occupancy-count reference model.
module tb_wptr_handler_lvl;

    logic       wclk;
    logic       wrst_n;
    logic       w_en;
    logic       ovf_clr;
    logic [3:0] g_rptr_sync;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wlevel;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: write count and read count modulo 16, flags from occupancy
    int m_wp   = 0;
    int m_rp   = 0;
    int m_lvl  = 0;
    bit m_full = 1'b0;
    bit m_af   = 1'b0;
    bit m_ovf  = 1'b0;

    wptr_handler_lvl #(.WIDTH(3), .AFULL_MARGIN(2)) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .w_en        (w_en),
        .ovf_clr     (ovf_clr),
        .g_rptr_sync (g_rptr_sync),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [14:0] exp_vec();
        return {4'(m_wp), gray(m_wp), m_full, m_af, 4'(m_lvl), m_ovf};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {b_wptr, g_wptr, full, almost_full, wlevel, overflow};
    endfunction

    task automatic step(input logic we, input logic clr, input int rp, input logic rst_n);
        bit acc;
        bit set;
        w_en        = we;
        ovf_clr     = clr;
        m_rp        = rp & 15;
        g_rptr_sync = gray(m_rp);
        wrst_n      = rst_n;
        @(posedge wclk);
        if (!rst_n) begin
            m_wp = 0; m_lvl = 0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        end else begin
            acc    = we && !m_full;
            set    = we && m_full;
            m_wp   = (m_wp + (acc ? 1 : 0)) & 15;
            m_lvl  = (m_wp - m_rp) & 15;
            m_full = (m_lvl == 8);
            m_af   = (m_lvl >= 6);
            m_ovf  = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 0, 1'b0);
            checks++;
            if (obs_vec() !== 15'd0) begin
                failures++;
                $display("FAIL reset_state: got %h expected %h", obs_vec(), 15'd0);
            end
        end
    endtask

    task automatic test_fill();
        bit af_seen_at6 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL fill_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (wlevel == 4'd6 && almost_full === 1'b1) af_seen_at6 = 1'b1;
        end
        checks++;
        if ({g_wptr, full, wlevel} !== {4'b1100, 1'b1, 4'd8}) begin
            failures++;
            $display("FAIL fill_end: got g=%b full=%b lvl=%0d expected g=1100 full=1 lvl=8", g_wptr, full, wlevel);
        end
        checks++;
        if (af_seen_at6 !== 1'b1) begin
            failures++;
            $display("FAIL fill_afull_at6: got %b expected 1", af_seen_at6);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b1);
        checks++;
        if ({b_wptr, g_wptr, overflow} !== {4'd8, 4'b1100, 1'b1}) begin
            failures++;
            $display("FAIL ovf_hold: got b=%0d g=%b ovf=%b expected b=8 g=1100 ovf=1", b_wptr, g_wptr, overflow);
        end
        step(1'b0, 1'b1, 0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        step(1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 0, 1'b1);
        checks++;
        if ({overflow, b_wptr} !== {1'b1, 4'd8}) begin
            failures++;
            $display("FAIL ovf_set_wins: got ovf=%b b=%0d expected ovf=1 b=8", overflow, b_wptr);
        end
    endtask

    task automatic test_drain();
        step(1'b0, 1'b0, 3, 1'b1);
        checks++;
        if ({full, wlevel, almost_full} !== {1'b0, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL drain_release: got full=%b lvl=%0d af=%b expected full=0 lvl=5 af=0", full, wlevel, almost_full);
        end
        step(1'b1, 1'b0, 3, 1'b1);
        checks++;
        if ({b_wptr, g_wptr, wlevel, almost_full} !== {4'd9, 4'b1101, 4'd6, 1'b1}) begin
            failures++;
            $display("FAIL drain_write: got b=%0d g=%b lvl=%0d af=%b expected b=9 g=1101 lvl=6 af=1", b_wptr, g_wptr, wlevel, almost_full);
        end
    endtask

    task automatic test_wrap();
        bit wrapped  = 1'b0;
        int max_lvl  = 0;
        bit any_full = 1'b0;
        logic [3:0] prev_b;
        logic [3:0] prev_g;
        for (int i = 0; i < 20; i++) begin
            prev_b = b_wptr;
            prev_g = g_wptr;
            step(1'b1, 1'b0, m_wp - 2, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (prev_b == 4'd15 && b_wptr == 4'd0 && prev_g == 4'b1000 && g_wptr == 4'b0000) wrapped = 1'b1;
            if (int'(wlevel) > max_lvl) max_lvl = int'(wlevel);
            if (full === 1'b1) any_full = 1'b1;
        end
        checks++;
        if ({wrapped, any_full} !== 2'b10 || max_lvl > 3) begin
            failures++;
            $display("FAIL wrap_summary: got wrapped=%b full_seen=%b max_lvl=%0d expected wrapped=1 full_seen=0 max_lvl<=3", wrapped, any_full, max_lvl);
        end
    endtask

    task automatic test_midreset();
        step(1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 1'b1);
        checks++;
        if (b_wptr !== 4'd5) begin
            failures++;
            $display("FAIL midrst_setup: got %0d expected 5", b_wptr);
        end
        step(1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (obs_vec() !== 15'd0) begin
            failures++;
            $display("FAIL midrst_zero: got %h expected %h", obs_vec(), 15'd0);
        end
        step(1'b1, 1'b0, 0, 1'b1);
        checks++;
        if ({b_wptr, g_wptr, wlevel} !== {4'd1, 4'b0001, 4'd1}) begin
            failures++;
            $display("FAIL midrst_first_write: got b=%0d g=%b lvl=%0d expected b=1 g=0001 lvl=1", b_wptr, g_wptr, wlevel);
        end
    endtask

    task automatic test_random();
        int rp;
        logic rst;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            rp  = m_rp;
            if ($urandom_range(0, 2) == 0) rp = m_rp + $urandom_range(0, (m_wp - m_rp) & 15);
            if (!rst) rp = 0;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), rp, rst);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        wrst_n      = 1'b0;
        w_en        = 1'b0;
        ovf_clr     = 1'b0;
        g_rptr_sync = 4'd0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wptr_handler_lvl.md
Name: wptr_handler_lvl

Overview:
Write-domain pointer stage of the asynchronous FIFO, directly upstream of the read-pointer handler. It owns the binary and Gray write pointers and produces the write address and the registered full flag. It also provides a fill-level estimate, an almost-full flag and a sticky overflow flag. The Gray write pointer is exported to the 2-flop synchronizer feeding the read domain. The read domain's Gray pointer arrives already synchronized into wclk.

Parameters:
WIDTH, 8, address width; FIFO depth DEPTH = 2^WIDTH; pointers are WIDTH+1 bits (legal: WIDTH >= 2)
AFULL_MARGIN, 4, almost_full asserts when level >= DEPTH - AFULL_MARGIN (legal: 1..DEPTH-1)

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  synchronous active-low reset
w_en  input  1  write request from producer
ovf_clr  input  1  clears sticky overflow
g_rptr_sync  input  WIDTH+1  Gray read pointer, already synchronized to wclk
b_wptr  output  WIDTH+1  binary write pointer; [WIDTH-1:0] is the RAM write address
g_wptr  output  WIDTH+1  Gray write pointer, to read-domain synchronizer
full  output  1  FIFO full (registered)
almost_full  output  1  level at or above threshold (registered)
wlevel  output  WIDTH+1  conservative fill level, 0..DEPTH (registered)
overflow  output  1  sticky: write attempted while full

Behaviour:
- Single clock wclk. Reset is synchronous, active-low, and sampled only on the wclk rising edge. wrst_n==0 forces b_wptr=0, g_wptr=0, full=0, almost_full=0, wlevel=0 and overflow=0, regardless of other inputs.
- Write acceptance: wr_acc = w_en & ~full. A write is accepted in a cycle where full==0 at the clock edge. The RAM write uses b_wptr[WIDTH-1:0] in that same cycle.
- b_wptr_next = b_wptr + wr_acc. The sum is computed at full WIDTH+1 bits and wraps modulo 2^(WIDTH+1); there is no truncation to WIDTH bits.
- g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1). g_wptr registers g_wptr_next, so g_wptr is always the Gray code of b_wptr. g_wptr changes by exactly 1 bit per accepted write.
- b_rptr_s = Gray-to-binary of g_rptr_sync. This is combinational: bit i = XOR of g_rptr_sync[WIDTH:i].
- full_next = (g_wptr_next == {~g_rptr_sync[WIDTH:WIDTH-1], g_rptr_sync[WIDTH-2:0]}). full registers full_next, so full is valid in the same cycle the pointer that causes it is visible.
- level_next = (b_wptr_next - b_rptr_s) mod 2^(WIDTH+1). wlevel registers level_next.
- almost_full registers (level_next >= DEPTH - AFULL_MARGIN).
- Overflow: set when w_en & full. Cleared when ovf_clr==1 and no set event occurs in that cycle. If set and clear occur in the same cycle, set wins. Otherwise overflow holds its value.
- Full boundary: w_en while full leaves b_wptr and g_wptr unchanged and sets overflow.
- Stale read pointer: g_rptr_sync lags the true read pointer. full, wlevel and almost_full are therefore pessimistic: they may read fuller than actual, never emptier. full deasserts the cycle after g_rptr_sync advances.
- Invariant: wlevel <= DEPTH at all times. wlevel==DEPTH if and only if full==1.
- Reset mid-operation: pointers return to 0 immediately at the edge and any write in that cycle is discarded. Resetting the read domain as well is a system-level requirement.
- No other state; no FSM beyond the pointer, full and overflow registers.

Test Plan:
(All tests: WIDTH=3, DEPTH=8, AFULL_MARGIN=2.)
1. Reset: w_en=1, ovf_clr=0, wrst_n=0 for 2 edges -> b_wptr=0, g_wptr=0, full=0, almost_full=0, wlevel=0, overflow=0. No pointer movement until wrst_n=1.
2. Fill: g_rptr_sync=0, w_en=1 for 8 cycles -> b_wptr steps 0..8 and after 8 writes g_wptr=4'b1100, full=1, wlevel=8. almost_full rises when wlevel reaches 6.
3. Overflow: while full, w_en=1 for 3 cycles -> b_wptr stays 8, overflow=1. ovf_clr=1 with w_en=0 -> overflow=0 next edge. ovf_clr=1 with w_en=1 while full -> overflow stays 1.
4. Drain: from full, set g_rptr_sync=4'b0010 (binary 3) -> next edge full=0, wlevel=5, almost_full=0. Then one w_en pulse -> b_wptr=9, g_wptr=4'b1101, wlevel=6, almost_full=1.
5. Wrap: 20 writes with g_rptr_sync kept 2 entries behind b_wptr -> b_wptr wraps 15->0 and g_wptr goes 4'b1000->4'b0000. wlevel never exceeds 3 and full is never asserted.
6. Reset mid-operation: at b_wptr=5 with w_en=1, pulse wrst_n=0 for one edge -> all outputs 0 and the write in that cycle is discarded. The first write after release lands at address 0.
